sync_stat_mc: RTL and testbench
===============================

SYNC_STAT_MC -- requirements
Module: sync_stat_mc

Interface
REQ-001 SHALL have parameter pCH_N, default 4, number of sync channels (range 2..16).
REQ-002 SHALL have parameter pTM_W, default 24, window counter width.
REQ-003 SHALL have parameter pST_W, default 8, per-channel count width.
REQ-004 SHALL have parameter pSAT, default 200, count saturation value (< 2**pST_W).
REQ-005 SHALL have parameter pLOCK_N, default 3, consecutive windows for lock hysteresis.
REQ-006 SHALL have port iclk  input  1  clock.
REQ-007 SHALL have port ireset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port iena  input  1  enable window start and continuation.
REQ-009 SHALL have port isop  input  pCH_N  per-channel start-of-packet pulses.
REQ-010 SHALL have port iframe_time  input  pTM_W  window length minus one.
REQ-011 SHALL have port iready  input  1  downstream accepts result.
REQ-012 SHALL have port ostat  output  pST_W  channel count being reported.
REQ-013 SHALL have port och  output  $clog2(pCH_N)  channel index of ostat.
REQ-014 SHALL have port oval  output  1  ostat/och valid.
REQ-015 SHALL have port oovr  output  1  sticky overrun flag.
REQ-016 SHALL have port olock  output  pCH_N  per-channel lock (macro-dependent, REQ-034).
REQ-017 SHALL have port ilock_thr  input  pST_W  lock threshold (macro-dependent, REQ-034).

Function
REQ-018 Window FSM SHALL have states W_IDLE, W_COUNT.
REQ-019 W_IDLE->W_COUNT SHALL occur when iena && |isop; the triggering pulses SHALL be counted; iframe_time SHALL be latched that cycle.
REQ-020 In W_COUNT, the window timer SHALL start at 0 and increment by 1 per cycle; terminal cycle is timer == latched iframe_time (window = iframe_time+1 cycles; iframe_time=0 gives 1-cycle window).
REQ-021 Each channel counter SHALL increment by 1 per isop bit in W_COUNT, saturating at pSAT; pulses on the terminal cycle SHALL be included.
REQ-022 On terminal cycle, all counts SHALL be snapshotted to result registers and counters/timer cleared; next state W_COUNT if iena (contiguous, new iframe_time latched), else W_IDLE.
REQ-023 iena deasserted mid-window SHALL NOT abort the window; it completes and reports.
REQ-024 Output FSM SHALL have states O_IDLE, O_DRAIN; snapshot moves O_IDLE->O_DRAIN one cycle after terminal cycle.
REQ-025 In O_DRAIN, channels SHALL be presented in order 0..pCH_N-1; oval high, ostat/och stable until oval && iready; after channel pCH_N-1 accepted, return to O_IDLE.
REQ-026 Snapshot arriving while O_DRAIN SHALL be discarded, old drain continues, oovr set; oovr SHALL clear only on reset.
REQ-027 Snapshot and drain completion in the same cycle SHALL be treated as no overrun; the new snapshot is drained next.

Reset
REQ-028 ireset low SHALL asynchronously force W_IDLE, O_IDLE, all counters/snapshots 0, ostat=0, och=0, oval=0, oovr=0, olock=0.
REQ-029 Reset mid-window or mid-drain SHALL discard all partial results; no oval after release until a new window completes.

Configuration
REQ-030 Macro SYNC_STAT_LOCK_EN SHALL enable the lock detector.
REQ-031 With it: per channel, olock SHALL set after pLOCK_N consecutive snapshots with count >= ilock_thr, clear after pLOCK_N consecutive with count < ilock_thr.
REQ-032 Lock SHALL update on every snapshot, including discarded (overrun) ones.
REQ-033 Lock SHALL update the cycle after the terminal cycle.
REQ-034 Without it: olock tied 0, ilock_thr ignored, no lock logic synthesised.

Structure
REQ-035 Package sync_stat_pkg SHALL hold window/output FSM enum typedefs and channel-index width constant function.
REQ-036 Sub-module sync_stat_ch SHALL implement one channel's saturating counter, snapshot and lock hysteresis; instantiated pCH_N times via generate.

Verification
REQ-037 pCH_N=4, iframe_time=9, iena=1, 3 pulses on ch0 and 5 on ch2 -> after 10 cycles, oval with (och,ostat)=(0,3),(1,0),(2,5),(3,0), iready=1.
REQ-038 300 pulses on ch1 in one window (iframe_time=999) -> ostat for ch1 = 200.
REQ-039 iready=0 held across next window end, iframe_time=4 -> oovr=1, first snapshot still drained intact.
REQ-040 SYNC_STAT_LOCK_EN, ilock_thr=5, ch0 counts 6,6,6 then 2,2,2 -> olock[0] rises after 3rd window, falls after 6th.
REQ-041 ireset pulsed mid-drain after channel 1 -> oval=0 immediately; no output until next full window.
REQ-042 iframe_time=0, single pulse on ch3 -> one-cycle window, ch3 reports 1.

Source files
------------

// File: rtl/sync_stat_pkg.sv
// ============================================================================
// Module      : sync_stat_pkg
// Description : Shared FSM state types and channel-index width helper for
//               the multi-channel sync statistics block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_stat_pkg;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_COUNT = 1'b1
  } win_state_t;

  typedef enum logic [0:0] {
    O_IDLE  = 1'b0,
    O_DRAIN = 1'b1
  } out_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_stat_ch.sv
// ============================================================================
// Module      : sync_stat_ch
// Description : One channel: saturating pulse counter, snapshot register and
//               optional lock hysteresis (enabled by SYNC_STAT_LOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_stat_ch
  import sync_stat_pkg::*;
#(
  parameter int pST_W   = 8,
  parameter int pSAT    = 200,
  parameter int pLOCK_N = 3
)(
  input  logic             iclk,
  input  logic             ireset,
  input  logic             icount_en,
  input  logic             isop,
  input  logic             iterm,
  input  logic             iload,
  input  logic [pST_W-1:0] ilock_thr,
  output logic [pST_W-1:0] osnap,
  output logic             olock
);

  localparam logic [pST_W-1:0] c_SAT = pST_W'(pSAT);

  logic [pST_W-1:0] r_cnt;
  logic [pST_W-1:0] r_snap;
  logic             w_inc;
  logic [pST_W-1:0] w_next;

  assign w_inc  = icount_en && isop && (r_cnt < c_SAT);
  assign w_next = w_inc ? (r_cnt + 1'b1) : r_cnt;

  // Presents the value the snapshot will hold next cycle, so the output
  // stage can pick up channel 0 in the same edge the snapshot is taken.
  assign osnap = iload ? w_next : r_snap;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else if (iterm) begin
      r_cnt <= '0;
      if (iload) begin
        r_snap <= w_next;
      end
    end else begin
      r_cnt <= w_next;
    end
  end

`ifdef SYNC_STAT_LOCK_EN
  localparam int               c_RUN_W    = $clog2(pLOCK_N + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(pLOCK_N);
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(pLOCK_N - 1);

  logic [c_RUN_W-1:0] r_hit_run;
  logic [c_RUN_W-1:0] r_miss_run;
  logic               r_lock;
  logic               w_hit;

  assign w_hit = (w_next >= ilock_thr);

  // Lock evaluates every window end, whether or not the snapshot is kept.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_hit_run  <= '0;
      r_miss_run <= '0;
      r_lock     <= 1'b0;
    end else if (iterm) begin
      if (w_hit) begin
        r_miss_run <= '0;
        if (r_hit_run < c_RUN_MAX) begin
          r_hit_run <= r_hit_run + 1'b1;
        end
        if (r_hit_run >= c_RUN_LAST) begin
          r_lock <= 1'b1;
        end
      end else begin
        r_hit_run <= '0;
        if (r_miss_run < c_RUN_MAX) begin
          r_miss_run <= r_miss_run + 1'b1;
        end
        if (r_miss_run >= c_RUN_LAST) begin
          r_lock <= 1'b0;
        end
      end
    end
  end

  assign olock = r_lock;
`else
  logic w_unused_thr;
  assign w_unused_thr = ^ilock_thr;
  assign olock        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/sync_stat_mc.sv
// ============================================================================
// Module      : sync_stat_mc
// Description : Windowed per-channel SOP counter with sequential result drain
//               and sticky overrun; lock detector under SYNC_STAT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_stat_mc
  import sync_stat_pkg::*;
#(
  parameter int pCH_N   = 4,
  parameter int pTM_W   = 24,
  parameter int pST_W   = 8,
  parameter int pSAT    = 200,
  parameter int pLOCK_N = 3
)(
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iena,
  input  logic [pCH_N-1:0]         isop,
  input  logic [pTM_W-1:0]         iframe_time,
  input  logic                     iready,
  output logic [pST_W-1:0]         ostat,
  output logic [$clog2(pCH_N)-1:0] och,
  output logic                     oval,
  output logic                     oovr,
  output logic [pCH_N-1:0]         olock,
  input  logic [pST_W-1:0]         ilock_thr
);

  localparam int                c_CH_W    = ch_idx_w(pCH_N);
  localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(pCH_N - 1);

  // ---------------------------------------------------------------- window
  win_state_t       r_wstate;
  logic [pTM_W-1:0] r_timer;
  logic [pTM_W-1:0] r_ft;
  logic             w_start;
  logic             w_count_en;
  logic             w_term;

  assign w_start    = (r_wstate == W_IDLE) && iena && (|isop);
  assign w_count_en = w_start || (r_wstate == W_COUNT);
  // The triggering cycle is window cycle 0, so a zero length ends at once.
  assign w_term     = (w_start && (iframe_time == '0)) ||
                      ((r_wstate == W_COUNT) && (r_timer == r_ft));

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_wstate <= W_IDLE;
      r_timer  <= '0;
      r_ft     <= '0;
    end else if (w_term) begin
      r_timer  <= '0;
      r_ft     <= iframe_time;
      r_wstate <= iena ? W_COUNT : W_IDLE;
    end else if (w_start) begin
      r_timer  <= pTM_W'(1);
      r_ft     <= iframe_time;
      r_wstate <= W_COUNT;
    end else if (r_wstate == W_COUNT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // -------------------------------------------------------------- channels
  out_state_t        r_ostate;
  logic [c_CH_W-1:0] r_och;
  logic [pST_W-1:0]  r_ostat;
  logic              r_oval;
  logic              r_oovr;
  logic              w_accept;
  logic              w_drain_done;
  logic              w_snap_take;
  logic [c_CH_W-1:0] w_och_inc;
  logic [pST_W-1:0]  w_snap [pCH_N];

  assign w_accept     = r_oval && iready;
  assign w_drain_done = w_accept && (r_och == c_LAST_CH);
  assign w_snap_take  = w_term && ((r_ostate == O_IDLE) || w_drain_done);
  assign w_och_inc    = r_och + 1'b1;

  for (genvar gi = 0; gi < pCH_N; gi++) begin : g_ch
    sync_stat_ch #(
      .pST_W   (pST_W),
      .pSAT    (pSAT),
      .pLOCK_N (pLOCK_N)
    ) u_ch (
      .iclk      (iclk),
      .ireset    (ireset),
      .icount_en (w_count_en),
      .isop      (isop[gi]),
      .iterm     (w_term),
      .iload     (w_snap_take),
      .ilock_thr (ilock_thr),
      .osnap     (w_snap[gi]),
      .olock     (olock[gi])
    );
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_ostate <= O_IDLE;
      r_och    <= '0;
      r_ostat  <= '0;
      r_oval   <= 1'b0;
      r_oovr   <= 1'b0;
    end else begin
      if (w_term && !w_snap_take) begin
        r_oovr <= 1'b1;
      end
      case (r_ostate)
        O_IDLE: begin
          if (w_snap_take) begin
            r_ostate <= O_DRAIN;
            r_oval   <= 1'b1;
            r_och    <= '0;
            r_ostat  <= w_snap[0];
          end
        end
        O_DRAIN: begin
          if (w_accept) begin
            if (r_och == c_LAST_CH) begin
              r_och <= '0;
              if (w_snap_take) begin
                r_ostat <= w_snap[0];
              end else begin
                r_ostate <= O_IDLE;
                r_oval   <= 1'b0;
                r_ostat  <= '0;
              end
            end else begin
              r_och   <= w_och_inc;
              r_ostat <= w_snap[w_och_inc];
            end
          end
        end
        default: begin
          r_ostate <= O_IDLE;
          r_oval   <= 1'b0;
        end
      endcase
    end
  end

  assign ostat = r_ostat;
  assign och   = r_och;
  assign oval  = r_oval;
  assign oovr  = r_oovr;

endmodule

`default_nettype wire

// File: tb/tb_sync_stat_mc.sv
// ============================================================================
// Module      : tb_sync_stat_mc
// Description : Directed bench for sync_stat_mc with a queue-based reference
//               model; lock expectations depend on SYNC_STAT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_stat_mc;

  localparam int CH     = 4;
  localparam int TM_W   = 24;
  localparam int ST_W   = 8;
  localparam int SAT    = 200;
  localparam int LOCK_N = 3;

  logic            iclk = 1'b0;
  logic            ireset = 1'b0;
  logic            iena = 1'b0;
  logic            iready = 1'b0;
  logic [CH-1:0]   isop = '0;
  logic [TM_W-1:0] iframe_time = '0;
  logic [ST_W-1:0] ilock_thr = '0;
  logic [ST_W-1:0] ostat;
  logic [1:0]      och;
  logic            oval;
  logic            oovr;
  logic [CH-1:0]   olock;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 iclk = ~iclk;

  sync_stat_mc #(
    .pCH_N   (CH),
    .pTM_W   (TM_W),
    .pST_W   (ST_W),
    .pSAT    (SAT),
    .pLOCK_N (LOCK_N)
  ) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .iena        (iena),
    .isop        (isop),
    .iframe_time (iframe_time),
    .iready      (iready),
    .ostat       (ostat),
    .och         (och),
    .oval        (oval),
    .oovr        (oovr),
    .olock       (olock),
    .ilock_thr   (ilock_thr)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------------- model
  bit          m_act;
  int          m_pos;
  int          m_len;
  int          m_cnt  [CH];
  int          m_hit  [CH];
  int          m_miss [CH];
  bit [CH-1:0] m_lock;
  bit          m_ovr;
  int          q_ch[$];
  int          q_st[$];

  task automatic m_clear();
    m_act = 0; m_pos = 0; m_len = 1; m_ovr = 0; m_lock = '0;
    q_ch.delete(); q_st.delete();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_hit[c] = 0; m_miss[c] = 0;
    end
  endtask

  task automatic m_step();
    bit start, counting, term;
    start    = !m_act && iena && (isop != '0);
    counting = m_act || start;
    if (start) begin
      m_act = 1; m_pos = 0; m_len = int'(iframe_time) + 1;
    end
    if (counting)
      for (int c = 0; c < CH; c++)
        if (isop[c] && m_cnt[c] < SAT) m_cnt[c]++;
    term = counting && (m_pos == m_len - 1);
    if (q_ch.size() > 0 && iready) begin
      void'(q_ch.pop_front());
      void'(q_st.pop_front());
    end
    if (term) begin
`ifdef SYNC_STAT_LOCK_EN
      for (int c = 0; c < CH; c++) begin
        if (m_cnt[c] >= int'(ilock_thr)) begin
          m_miss[c] = 0; m_hit[c]++;
          if (m_hit[c] >= LOCK_N) m_lock[c] = 1'b1;
        end else begin
          m_hit[c] = 0; m_miss[c]++;
          if (m_miss[c] >= LOCK_N) m_lock[c] = 1'b0;
        end
      end
`endif
      if (q_ch.size() == 0) begin
        for (int c = 0; c < CH; c++) begin
          q_ch.push_back(c);
          q_st.push_back(m_cnt[c]);
        end
      end else begin
        m_ovr = 1;
      end
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      if (iena) begin
        m_pos = 0; m_len = int'(iframe_time) + 1;
      end else begin
        m_act = 0;
      end
    end else if (counting) begin
      m_pos++;
    end
  endtask

  always @(posedge iclk or negedge ireset) begin
    if (!ireset) m_clear();
    else         m_step();
  end

  always @(negedge iclk) begin
    if (ireset) begin
      chk("oval", int'(oval), int'(q_ch.size() > 0));
      if (q_ch.size() > 0) begin
        chk("och", int'(och), q_ch[0]);
        chk("ostat", int'(ostat), q_st[0]);
      end
      chk("oovr", int'(oovr), int'(m_ovr));
      chk("olock", int'(olock), int'(m_lock));
    end
  end

  // Record of accepted results for the literal checks.
  int log_ch[$];
  int log_st[$];
  always @(posedge iclk) begin
    if (ireset && oval && iready) begin
      log_ch.push_back(int'(och));
      log_st.push_back(int'(ostat));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int n);
    iena = 1'b0;
    isop = '0;
    repeat (n) cyc();
  endtask

  task automatic win_ch(input int ch, input int n, input int ft);
    iframe_time = TM_W'(ft);
    for (int i = 0; i <= ft; i++) begin
      iena = (i == 0);
      isop = '0;
      if (i < n) isop[ch] = 1'b1;
      cyc();
    end
    iena = 1'b0;
    isop = '0;
  endtask

  task automatic do_reset();
    ireset = 1'b0;
    repeat (2) cyc();
    ireset = 1'b1;
  endtask

  task automatic expect_log(input string nm, input int e0, input int e1,
                            input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_len"}, log_ch.size(), CH);
    for (int i = 0; i < CH && i < log_ch.size(); i++) begin
      chk({nm, "_ch"}, log_ch[i], i);
      chk({nm, "_st"}, log_st[i], e[i]);
    end
  endtask

  logic [CH-1:0] t1_pat [10];
  logic [CH-1:0] t3_pat [12];
  logic [CH-1:0] t3_ena;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk_exp;
    t1_pat = '{4'b0101, 4'b0001, 4'b0100, 4'b0101, 4'b0100,
               4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    t3_pat = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
               4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    do_reset();
    chk("rst_oval", int'(oval), 0);
    chk("rst_oovr", int'(oovr), 0);
    chk("rst_och", int'(och), 0);
    chk("rst_ostat", int'(ostat), 0);
    chk("rst_olock", int'(olock), 0);

    // Basic window: ch0=3, ch2=5 over a 10-cycle window.
    log_ch.delete(); log_st.delete();
    iready = 1'b1;
    iframe_time = TM_W'(9);
    for (int i = 0; i < 10; i++) begin
      iena = (i == 0);
      isop = t1_pat[i];
      cyc();
    end
    idle(8);
    expect_log("basic", 3, 0, 5, 0);

    // Saturation.
    log_ch.delete(); log_st.delete();
    win_ch(1, 300, 999);
    idle(8);
    expect_log("sat", 0, 200, 0, 0);

    // Two contiguous windows while the drain is stalled.
    log_ch.delete(); log_st.delete();
    iready = 1'b0;
    iframe_time = TM_W'(4);
    for (int i = 0; i < 12; i++) begin
      iena = (i <= 5);
      isop = t3_pat[i];
      cyc();
    end
    idle(3);
    chk("ovr_flag", int'(oovr), 1);
    iready = 1'b1;
    idle(8);
    expect_log("ovr", 1, 1, 0, 0);
    chk("ovr_sticky", int'(oovr), 1);

    // Lock hysteresis on ch0.
    do_reset();
    ilock_thr = ST_W'(5);
    iready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      win_ch(0, (w < 3) ? 6 : 2, 9);
      idle(6);
`ifdef SYNC_STAT_LOCK_EN
      lk_exp = (w >= 2 && w <= 4) ? 1 : 0;
`else
      lk_exp = 0;
`endif
      chk("lock_lit", int'(olock[0]), lk_exp);
    end

    // Reset in the middle of a drain.
    log_ch.delete(); log_st.delete();
    iready = 1'b0;
    win_ch(2, 3, 5);
    iready = 1'b1;
    cyc();
    cyc();
    iready = 1'b0;
    ireset = 1'b0;
    #1;
    chk("mid_rst_oval", int'(oval), 0);
    chk("mid_rst_och", int'(och), 0);
    cyc();
    ireset = 1'b1;
    iready = 1'b1;
    idle(20);
    chk("mid_rst_log", log_ch.size(), 2);
    log_ch.delete(); log_st.delete();
    win_ch(2, 4, 3);
    idle(8);
    expect_log("post_rst", 0, 0, 4, 0);

    // One-cycle window.
    log_ch.delete(); log_st.delete();
    win_ch(3, 1, 0);
    idle(8);
    expect_log("ft0", 0, 0, 0, 1);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
